// File: rtl/adder_operand_feeder_pkg.sv
// Shared types and constants for the adder operand feeder.
// Optional stall input is enabled by defining FEEDER_STALL_EN.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

    localparam int unsigned FEEDER_WIDTH = 32;
    localparam int unsigned FEEDER_DEPTH = 4;

    // Index width is clog2(depth), but never narrower than one bit.
    function automatic int unsigned calc_idx_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/adder_operand_feeder_if.sv
// Batch input handshake plus adder-side issue/result signals of the feeder.
// Optional stall input (FEEDER_STALL_EN) is a plain port on the top, not part of this bundle.
interface adder_operand_feeder_if
    import feeder_pkg::*;
#(
    parameter int unsigned WIDTH = FEEDER_WIDTH,
    parameter int unsigned DEPTH = FEEDER_DEPTH
) ();
    localparam int unsigned IDX_W = calc_idx_w(DEPTH);

    // Handshake: a batch transfers on a rising clk edge where in_valid && in_ready;
    // in_a/in_b/in_ci must be stable while in_valid is high, and in_ready is only
    // high while the feeder is idle.
    logic                        in_valid;
    logic                        in_ready;
    logic [DEPTH-1:0][WIDTH-1:0] in_a;
    logic [DEPTH-1:0][WIDTH-1:0] in_b;
    logic                        in_ci;

    logic [WIDTH-1:0]            op_a;
    logic [WIDTH-1:0]            op_b;
    logic                        op_ci;
    logic                        op_valid;
    logic [IDX_W-1:0]            op_index;

    logic                        res_valid;
    logic [IDX_W-1:0]            res_index;
    logic                        batch_done;
    logic                        busy;

    modport master (
        output in_valid, in_a, in_b, in_ci,
        input  in_ready, op_a, op_b, op_ci, op_valid, op_index,
        input  res_valid, res_index, batch_done, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ci,
        output in_ready, op_a, op_b, op_ci, op_valid, op_index,
        output res_valid, res_index, batch_done, busy
    );

endinterface

// File: rtl/adder_operand_feeder_latency_pipe.sv
// Delay line for {valid, index} matching the adder latency; advances every cycle.
// Synchronous active-low clear empties every stage.
module feeder_latency_pipe
    import feeder_pkg::*;
#(
    parameter int unsigned ADD_LATENCY = 1,
    parameter int unsigned IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_index,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index
);
    logic [ADD_LATENCY-1:0]            vld_q, vld_d;
    logic [ADD_LATENCY-1:0][IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        vld_d[0] = in_valid;
        idx_d[0] = in_index;
        for (int i = 1; i < int'(ADD_LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign out_valid = vld_q[ADD_LATENCY-1];
    assign out_index = idx_q[ADD_LATENCY-1];

endmodule

// File: rtl/adder_operand_feeder.sv
// Issue stage for the sliced adder: latches a batch of operand pairs and issues one per cycle.
// Define FEEDER_STALL_EN to add a stall input that pauses issue without stopping the result pipe.
module adder_operand_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned WIDTH       = FEEDER_WIDTH,
    parameter int unsigned DEPTH       = FEEDER_DEPTH,
    parameter int unsigned ADD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef FEEDER_STALL_EN
    input  logic                   stall,
`endif
    adder_operand_feeder_if.slave  bus,
    output feeder_state_e          state_dbg
);
    localparam int unsigned      IDX_W    = calc_idx_w(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    feeder_state_e               state_q, state_d;
    logic [IDX_W-1:0]            cnt_q, cnt_d;
    logic [DEPTH-1:0][WIDTH-1:0] a_q, a_d;
    logic [DEPTH-1:0][WIDTH-1:0] b_q, b_d;
    logic                        ci_q, ci_d;

    logic                        stall_act;
    logic                        in_ready;
    logic                        op_valid;
    logic                        op_ci;
    logic [WIDTH-1:0]            op_a;
    logic [WIDTH-1:0]            op_b;
    logic [IDX_W-1:0]            op_index;
    logic                        res_valid;
    logic [IDX_W-1:0]            res_index;
    logic                        batch_done;

`ifdef FEEDER_STALL_EN
    assign stall_act = stall;
`else
    assign stall_act = 1'b0;
`endif

    assign batch_done = res_valid && (res_index == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        ci_d     = ci_q;
        in_ready = 1'b0;
        op_valid = 1'b0;
        op_ci    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        op_index = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    ci_d    = bus.in_ci;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A stalled cycle issues nothing and leaves the counter where it is.
                if (!stall_act) begin
                    op_valid = 1'b1;
                    op_index = cnt_q;
                    op_a     = a_q[cnt_q];
                    op_b     = b_q[cnt_q];
                    op_ci    = ci_q;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (batch_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ci_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ci_q    <= ci_d;
        end
    end

    feeder_latency_pipe #(
        .ADD_LATENCY (ADD_LATENCY),
        .IDX_W       (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (op_valid),
        .in_index  (op_index),
        .out_valid (res_valid),
        .out_index (res_index)
    );

    assign bus.in_ready   = in_ready;
    assign bus.op_valid   = op_valid;
    assign bus.op_index   = op_index;
    assign bus.op_a       = op_a;
    assign bus.op_b       = op_b;
    assign bus.op_ci      = op_ci;
    assign bus.res_valid  = res_valid;
    assign bus.res_index  = res_index;
    assign bus.batch_done = batch_done;
    assign bus.busy       = (state_q != IDLE);
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_adder_operand_feeder.sv
// Bench for adder_operand_feeder: two instances (DEPTH=4/LAT=1 and DEPTH=2/LAT=4)
// compared per cycle against a schedule model; stall scenarios only when FEEDER_STALL_EN is defined.
module tb_adder_operand_feeder;
    import feeder_pkg::*;

    typedef struct packed {
        logic        opv;
        logic [3:0]  opidx;
        logic [31:0] opa;
        logic [31:0] opb;
        logic        opci;
        logic        resv;
        logic [3:0]  residx;
        logic        done;
        logic        ready;
        logic        busy;
    } trace_t;

    localparam int NC_MAX = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef FEEDER_STALL_EN
    logic stall4 = 1'b0;
    logic stall2 = 1'b0;
`endif

    adder_operand_feeder_if #(.WIDTH(32), .DEPTH(4)) if4 ();
    adder_operand_feeder_if #(.WIDTH(32), .DEPTH(2)) if2 ();
    feeder_state_e st4, st2;

    adder_operand_feeder #(.WIDTH(32), .DEPTH(4), .ADD_LATENCY(1)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FEEDER_STALL_EN
        .stall     (stall4),
`endif
        .bus       (if4.slave),
        .state_dbg (st4)
    );

    adder_operand_feeder #(.WIDTH(32), .DEPTH(2), .ADD_LATENCY(4)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FEEDER_STALL_EN
        .stall     (stall2),
`endif
        .bus       (if2.slave),
        .state_dbg (st2)
    );

    int checks   = 0;
    int failures = 0;

    trace_t      exp_tr [NC_MAX];
    logic [31:0] m_a    [16];
    logic [31:0] m_b    [16];
    logic        m_ci;
    bit          m_stall[NC_MAX];
    logic [3:0]  exp_q[$];

    // Model: pairs issue in order on the first non-stalled cycles after the accept,
    // each result appears lat cycles after its issue, the feeder is busy until the last result.
    function automatic void clear_model();
        for (int c = 0; c < NC_MAX; c++) begin
            exp_tr[c]       = '0;
            exp_tr[c].ready = 1'b1;
            m_stall[c]      = 1'b0;
        end
    endfunction

    function automatic void add_batch(input int origin, input int depth, input int lat);
        int c    = origin + 1;
        int last = origin;
        for (int k = 0; k < depth; k++) begin
            while (m_stall[c] && c < NC_MAX - 1) c++;
            if (c + lat < NC_MAX) begin
                exp_tr[c].opv          = 1'b1;
                exp_tr[c].opidx        = 4'(k);
                exp_tr[c].opa          = m_a[k];
                exp_tr[c].opb          = m_b[k];
                exp_tr[c].opci         = m_ci;
                exp_tr[c+lat].resv     = 1'b1;
                exp_tr[c+lat].residx   = 4'(k);
                exp_tr[c+lat].done     = (k == depth - 1);
            end
            last = c + lat;
            c++;
        end
        for (int x = origin + 1; x <= last && x < NC_MAX; x++) begin
            exp_tr[x].ready = 1'b0;
            exp_tr[x].busy  = 1'b1;
        end
    endfunction

    function automatic trace_t sample4();
        trace_t t;
        t.opv    = if4.op_valid;
        t.opidx  = 4'(if4.op_index);
        t.opa    = if4.op_a;
        t.opb    = if4.op_b;
        t.opci   = if4.op_ci;
        t.resv   = if4.res_valid;
        t.residx = 4'(if4.res_index);
        t.done   = if4.batch_done;
        t.ready  = if4.in_ready;
        t.busy   = if4.busy;
        return t;
    endfunction

    function automatic trace_t sample2();
        trace_t t;
        t.opv    = if2.op_valid;
        t.opidx  = 4'(if2.op_index);
        t.opa    = if2.op_a;
        t.opb    = if2.op_b;
        t.opci   = if2.op_ci;
        t.resv   = if2.res_valid;
        t.residx = 4'(if2.res_index);
        t.done   = if2.batch_done;
        t.ready  = if2.in_ready;
        t.busy   = if2.busy;
        return t;
    endfunction

    task automatic drive4_from_model();
        for (int k = 0; k < 4; k++) begin
            if4.in_a[k] = m_a[k];
            if4.in_b[k] = m_b[k];
        end
        if4.in_ci = m_ci;
    endtask

    task automatic random_model_data();
        for (int k = 0; k < 16; k++) begin
            m_a[k] = $urandom;
            m_b[k] = $urandom;
        end
        m_ci = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        trace_t idle;
        trace_t obs;
        idle       = '0;
        idle.ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = sample4();
        checks++;
        if (obs !== idle) begin
            failures++;
            $display("FAIL reset_dut4 got=%h exp=%h", obs, idle);
        end
        obs = sample2();
        checks++;
        if (obs !== idle) begin
            failures++;
            $display("FAIL reset_dut2 got=%h exp=%h", obs, idle);
        end
        checks++;
        if (st4 !== IDLE || st2 !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d/%0d exp=%0d", st4, st2, IDLE);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        obs = sample4();
        checks++;
        if (obs !== idle) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs, idle);
        end
    endtask

    task automatic test_basic();
        trace_t obs;
        logic [3:0] e;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            clear_model();
            if (b == 0) begin
                m_a[0] = 32'd1; m_a[1] = 32'd2; m_a[2] = 32'd3; m_a[3] = 32'hFFFF_FFFF;
                for (int k = 0; k < 4; k++) m_b[k] = 32'd1;
                m_ci = 1'b0;
            end else begin
                random_model_data();
            end
            add_batch(0, 4, 1);
            exp_q = {4'd0, 4'd1, 4'd2, 4'd3};
            drive4_from_model();
            if4.in_valid = 1'b1;
            @(posedge clk); #1;
            if4.in_valid = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                obs = sample4();
                checks++;
                if (obs !== exp_tr[c]) begin
                    failures++;
                    $display("FAIL basic b=%0d c=%0d got=%h exp=%h", b, c, obs, exp_tr[c]);
                end
                if (obs.resv === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL basic_extra_result b=%0d c=%0d got=%0d exp=none", b, c, obs.residx);
                    end else begin
                        e = exp_q.pop_front();
                        if (obs.residx !== e) begin
                            failures++;
                            $display("FAIL basic_res_order b=%0d c=%0d got=%0d exp=%0d", b, c, obs.residx, e);
                        end
                    end
                end
                @(posedge clk); #1;
            end
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL basic_missing_results b=%0d got=%0d exp=0", b, exp_q.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        trace_t obs;
        @(posedge clk); #1;
        clear_model();
        random_model_data();
        add_batch(0, 4, 1);
        drive4_from_model();
        if4.in_valid = 1'b1;
        @(posedge clk); #1;
        random_model_data();
        add_batch(6, 4, 1);
        drive4_from_model();
        for (int c = 1; c <= 14; c++) begin
            if (c == 7) if4.in_valid = 1'b0;
            @(negedge clk);
            obs = sample4();
            checks++;
            if (obs !== exp_tr[c]) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs, exp_tr[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_valid();
        trace_t obs;
        @(posedge clk); #1;
        clear_model();
        random_model_data();
        add_batch(0, 4, 1);
        drive4_from_model();
        if4.in_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 5) begin
                if4.in_valid = 1'($urandom_range(0, 1));
                for (int k = 0; k < 4; k++) begin
                    if4.in_a[k] = $urandom;
                    if4.in_b[k] = $urandom;
                end
                if4.in_ci = ~m_ci;
            end else begin
                if4.in_valid = 1'b0;
            end
            @(negedge clk);
            obs = sample4();
            checks++;
            if (obs !== exp_tr[c]) begin
                failures++;
                $display("FAIL ignore_valid c=%0d got=%h exp=%h", c, obs, exp_tr[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        trace_t obs;
        @(posedge clk); #1;
        clear_model();
        random_model_data();
        add_batch(0, 4, 1);
        for (int c = 4; c < NC_MAX; c++) begin
            exp_tr[c]       = '0;
            exp_tr[c].ready = 1'b1;
        end
        drive4_from_model();
        if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) rst_n = 1'b0;
            if (c == 4) rst_n = 1'b1;
            @(negedge clk);
            obs = sample4();
            checks++;
            if (obs !== exp_tr[c]) begin
                failures++;
                $display("FAIL mid_reset c=%0d got=%h exp=%h", c, obs, exp_tr[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_latency4();
        trace_t obs;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            clear_model();
            random_model_data();
            if (b == 0) m_ci = 1'b1;
            add_batch(0, 2, 4);
            for (int k = 0; k < 2; k++) begin
                if2.in_a[k] = m_a[k];
                if2.in_b[k] = m_b[k];
            end
            if2.in_ci    = m_ci;
            if2.in_valid = 1'b1;
            @(posedge clk); #1;
            if2.in_valid = 1'b0;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                obs = sample2();
                checks++;
                if (obs !== exp_tr[c]) begin
                    failures++;
                    $display("FAIL latency4 b=%0d c=%0d got=%h exp=%h", b, c, obs, exp_tr[c]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

`ifdef FEEDER_STALL_EN
    task automatic test_stall();
        trace_t obs;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            clear_model();
            random_model_data();
            if (b == 0) begin
                m_stall[3] = 1'b1;
                m_stall[4] = 1'b1;
            end else begin
                for (int c = 1; c <= 12; c++) m_stall[c] = ($urandom_range(0, 2) == 0);
            end
            add_batch(0, 4, 1);
            drive4_from_model();
            if4.in_valid = 1'b1;
            @(posedge clk); #1;
            if4.in_valid = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                stall4 = m_stall[c];
                @(negedge clk);
                obs = sample4();
                checks++;
                if (obs !== exp_tr[c]) begin
                    failures++;
                    $display("FAIL stall b=%0d c=%0d got=%h exp=%h", b, c, obs, exp_tr[c]);
                end
                @(posedge clk); #1;
            end
            stall4 = 1'b0;
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        if4.in_valid = 1'b0;
        if4.in_a     = '0;
        if4.in_b     = '0;
        if4.in_ci    = 1'b0;
        if2.in_valid = 1'b0;
        if2.in_a     = '0;
        if2.in_b     = '0;
        if2.in_ci    = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_valid();
        test_mid_reset();
        test_latency4();
`ifdef FEEDER_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
